paddle_ai_driver: RTL and testbench
===================================

PADDLE_AI_DRIVER -- requirements
Module: paddle_ai_driver

Interface
REQ-001 Parameter UPDATE_PERIOD, default 4: clock cycles per decision tick, >=1.
REQ-002 Parameter REACT_TICKS, default 3: ticks spent in WAIT before tracking, >=1.
REQ-003 Parameter DEADBAND, default 2: pixel tolerance inside which no button is pressed.
REQ-004 Parameter CENTER_Y, default 160: Y rest position used while the ball moves away.
REQ-005 clock  input  1  system clock; all state updates on the rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 enable  input  1  1 = AI drives the paddle; 0 = AI idle, buttons released.
REQ-008 ballApproach  input  1  1 = ball X velocity is toward this paddle.
REQ-009 ballY  input  9  ball centre Y, unsigned.
REQ-010 paddleYValue  input  9  current paddle centre Y from the paddle mover, unsigned.
REQ-011 button  output  2  active-low commands to the paddle mover; bit0 low = move down (Y increases), bit1 low = move up (Y decreases).
REQ-012 aiState  output  2  current state: IDLE=0, WAIT=1, TRACK=2, RECENTER=3.

Function
REQ-013 The tick counter SHALL count 0..UPDATE_PERIOD-1 and wrap to 0; tick is asserted in the cycle where the count equals UPDATE_PERIOD-1.
REQ-014 State transitions and button updates SHALL occur only on tick cycles, except for the enable-low and reset rules.
REQ-015 On a tick the next state SHALL be determined as follows:
- IDLE: ballApproach=1 -> WAIT; otherwise -> RECENTER.
- WAIT: ballApproach=0 -> RECENTER; otherwise, reactCount==REACT_TICKS-1 -> TRACK; otherwise stay and increment reactCount.
- TRACK: ballApproach=0 -> RECENTER; otherwise stay.
- RECENTER: ballApproach=1 -> WAIT; otherwise stay.
REQ-016 reactCount SHALL be cleared on every entry to WAIT, so WAIT lasts exactly REACT_TICKS ticks when ballApproach stays 1.
REQ-017 In WAIT, ballApproach=0 SHALL take priority over reaction completion.
REQ-018 enable=0 in any state SHALL force state IDLE and button=2'b11 on the next clock edge, independent of tick; the tick counter keeps running.
REQ-019 On a tick, button SHALL be computed from the next state:
- IDLE or WAIT -> 2'b11.
- TRACK -> target = ballY.
- RECENTER -> target = CENTER_Y.
REQ-020 For TRACK and RECENTER the button value SHALL be:
- target > paddleYValue + DEADBAND -> 2'b10 (down).
- target + DEADBAND < paddleYValue -> 2'b01 (up).
- otherwise -> 2'b11.
REQ-021 Comparisons SHALL use at least 10-bit unsigned arithmetic so that no sum wraps for any 9-bit input (0..511).
REQ-022 button SHALL be registered and held constant between ticks; 2'b00 SHALL never be driven.
REQ-023 aiState SHALL reflect the registered state with no added latency.
REQ-024 Inputs SHALL be sampled only on tick cycles; changes between ticks have no effect until the next tick.

Reset
REQ-025 While reset=1, state SHALL be IDLE, button=2'b11, aiState=0, tick counter=0 and reactCount=0 on the next edge.
REQ-026 reset SHALL override enable and tick, including mid-WAIT and mid-TRACK.
REQ-027 After reset is released, the first tick SHALL occur UPDATE_PERIOD cycles later.

Verification
REQ-028 Reset check: assert reset for 2 cycles from any state -> button=2'b11, aiState=0; first tick occurs in the 4th cycle after release.
REQ-029 Reaction delay: enable=1, ballApproach=1, ballY=200, paddleYValue=160 -> WAIT at tick 1, button=2'b11 through ticks 1-3, TRACK with button=2'b10 at tick 4.
REQ-030 Deadband in TRACK with paddleYValue=160:
- ballY=162 -> 2'b11.
- ballY=163 -> 2'b10.
- ballY=158 -> 2'b11.
- ballY=157 -> 2'b01.
REQ-031 Recenter: in TRACK, drop ballApproach with paddleYValue=100 -> RECENTER and 2'b10 at the next tick; paddleYValue=159 -> 2'b11; raise ballApproach -> WAIT and 2'b11.
REQ-032 Enable drop: enable=0 mid-TRACK between ticks -> IDLE and 2'b11 on the next edge; button never equals 2'b00 over a 10k-cycle random run.
REQ-033 Extremes in TRACK:
- ballY=0, paddleYValue=0 -> 2'b11.
- ballY=511, paddleYValue=0 -> 2'b10.
- ballY=0, paddleYValue=511 -> 2'b01.

Source files
------------

// File: rtl/paddle_ai_driver.sv
// Paddle AI: ticked FSM that reacts to an approaching ball and steers
// the paddle mover through active-low buttons.
module paddle_ai_driver #(
  parameter int UPDATE_PERIOD = 4,
  parameter int REACT_TICKS   = 3,
  parameter int DEADBAND      = 2,
  parameter int CENTER_Y      = 160
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       enable,
  input  logic       ballApproach,
  input  logic [8:0] ballY,
  input  logic [8:0] paddleYValue,
  output logic [1:0] button,
  output logic [1:0] aiState
);

  localparam int CW = (UPDATE_PERIOD > 1) ? $clog2(UPDATE_PERIOD) : 1;
  localparam int RW = (REACT_TICKS > 1) ? $clog2(REACT_TICKS) : 1;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_WAIT     = 2'd1,
    S_TRACK    = 2'd2,
    S_RECENTER = 2'd3
  } ai_state_t;

  ai_state_t   state, next_state;
  logic [CW-1:0] tick_count;
  logic [RW-1:0] react_count, react_next;
  logic [1:0]  button_next;
  logic [9:0]  target, paddle_w, band;
  logic        tick;

  assign tick     = (tick_count == CW'(UPDATE_PERIOD - 1));
  assign aiState  = state;
  assign paddle_w = {1'b0, paddleYValue};
  assign band     = 10'(DEADBAND);

  always_comb begin
    next_state = state;
    react_next = react_count;
    unique case (state)
      S_IDLE: begin
        next_state = ballApproach ? S_WAIT : S_RECENTER;
        react_next = '0;
      end
      S_WAIT: begin
        if (!ballApproach) begin
          next_state = S_RECENTER;
        end else if (react_count == RW'(REACT_TICKS - 1)) begin
          next_state = S_TRACK;
        end else begin
          react_next = react_count + 1'b1;
        end
      end
      S_TRACK: begin
        if (!ballApproach) next_state = S_RECENTER;
      end
      S_RECENTER: begin
        if (ballApproach) begin
          next_state = S_WAIT;
          react_next = '0;
        end
      end
      default: next_state = S_IDLE;
    endcase
  end

  // Widened to 10 bits so target/paddle plus deadband never wraps.
  always_comb begin
    target      = (next_state == S_TRACK) ? {1'b0, ballY} : 10'(CENTER_Y);
    button_next = 2'b11;
    if (next_state == S_TRACK || next_state == S_RECENTER) begin
      if (target > paddle_w + band) begin
        button_next = 2'b10;
      end else if (target + band < paddle_w) begin
        button_next = 2'b01;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      tick_count  <= '0;
      state       <= S_IDLE;
      button      <= 2'b11;
      react_count <= '0;
    end else begin
      tick_count <= tick ? '0 : tick_count + 1'b1;
      if (!enable) begin
        state       <= S_IDLE;
        button      <= 2'b11;
        react_count <= '0;
      end else if (tick) begin
        state       <= next_state;
        button      <= button_next;
        react_count <= react_next;
      end
    end
  end

endmodule

// File: tb/tb_paddle_ai_driver.sv
// Directed bench for paddle_ai_driver: reaction delay, deadband,
// recenter, enable drop, extremes and a random no-2'b00 sweep.
module tb_paddle_ai_driver;

  logic       clock = 1'b0;
  logic       reset;
  logic       enable;
  logic       ballApproach;
  logic [8:0] ballY;
  logic [8:0] paddleYValue;
  logic [1:0] button;
  logic [1:0] aiState;

  int tests = 0;
  int fails = 0;
  int ph    = 0;

  paddle_ai_driver dut (
    .clock(clock),
    .reset(reset),
    .enable(enable),
    .ballApproach(ballApproach),
    .ballY(ballY),
    .paddleYValue(paddleYValue),
    .button(button),
    .aiState(aiState)
  );

  always #5 clock = ~clock;

  task automatic clk(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      ph = (ph + 1) % 4;
    end
    #1;
  endtask

  task automatic next_tick();
    clk(1);
    while (ph != 0) clk(1);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clk(2);
    ph = 0;
    reset = 1'b0;
  endtask

  task automatic go_track(input logic [8:0] by, input logic [8:0] py);
    enable = 1'b1;
    ballApproach = 1'b1;
    ballY = by;
    paddleYValue = py;
    do_reset();
    repeat (4) next_tick();
  endtask

  task automatic test_reset();
    go_track(9'd300, 9'd160);
    do_reset();
    tests++;
    if (button !== 2'b11 || aiState !== 2'd0) begin
      fails++;
      $display("FAIL reset_state: button=%b state=%0d want 11/0",
               button, aiState);
    end
    clk(3);
    tests++;
    if (aiState !== 2'd0) begin
      fails++;
      $display("FAIL reset_early_tick: state=%0d want 0", aiState);
    end
    clk(1);
    tests++;
    if (aiState !== 2'd1 || button !== 2'b11) begin
      fails++;
      $display("FAIL reset_first_tick: state=%0d button=%b want 1/11",
               aiState, button);
    end
  endtask

  task automatic test_reaction();
    logic [1:0] ws [1:4];
    logic [1:0] wb [1:4];
    ws = '{2'd1, 2'd1, 2'd1, 2'd2};
    wb = '{2'b11, 2'b11, 2'b11, 2'b10};
    enable = 1'b1;
    ballApproach = 1'b1;
    ballY = 9'd200;
    paddleYValue = 9'd160;
    do_reset();
    for (int t = 1; t <= 4; t++) begin
      next_tick();
      tests++;
      if (aiState !== ws[t] || button !== wb[t]) begin
        fails++;
        $display("FAIL reaction_tick%0d: state=%0d button=%b want %0d/%b",
                 t, aiState, button, ws[t], wb[t]);
      end
    end
  endtask

  task automatic test_sampling();
    go_track(9'd300, 9'd160);
    clk(1);
    ballY = 9'd10;
    clk(2);
    tests++;
    if (button !== 2'b10) begin
      fails++;
      $display("FAIL hold_between_ticks: button=%b want 10", button);
    end
    clk(1);
    tests++;
    if (button !== 2'b01) begin
      fails++;
      $display("FAIL sample_on_tick: button=%b want 01", button);
    end
  endtask

  task automatic test_deadband();
    logic [8:0] ys [4];
    logic [1:0] wb [4];
    ys = '{9'd162, 9'd163, 9'd158, 9'd157};
    wb = '{2'b11, 2'b10, 2'b11, 2'b01};
    go_track(9'd160, 9'd160);
    for (int i = 0; i < 4; i++) begin
      ballY = ys[i];
      next_tick();
      tests++;
      if (button !== wb[i] || aiState !== 2'd2) begin
        fails++;
        $display("FAIL deadband_y%0d: button=%b state=%0d want %b/2",
                 ys[i], button, aiState, wb[i]);
      end
    end
  endtask

  task automatic test_recenter();
    go_track(9'd160, 9'd100);
    ballApproach = 1'b0;
    next_tick();
    tests++;
    if (aiState !== 2'd3 || button !== 2'b10) begin
      fails++;
      $display("FAIL recenter_enter: state=%0d button=%b want 3/10",
               aiState, button);
    end
    paddleYValue = 9'd159;
    next_tick();
    tests++;
    if (aiState !== 2'd3 || button !== 2'b11) begin
      fails++;
      $display("FAIL recenter_settle: state=%0d button=%b want 3/11",
               aiState, button);
    end
    ballApproach = 1'b1;
    next_tick();
    tests++;
    if (aiState !== 2'd1 || button !== 2'b11) begin
      fails++;
      $display("FAIL recenter_to_wait: state=%0d button=%b want 1/11",
               aiState, button);
    end
  endtask

  task automatic test_wait_abort();
    enable = 1'b1;
    ballApproach = 1'b1;
    ballY = 9'd200;
    paddleYValue = 9'd160;
    do_reset();
    repeat (3) next_tick();
    ballApproach = 1'b0;
    next_tick();
    tests++;
    if (aiState !== 2'd3) begin
      fails++;
      $display("FAIL wait_abort: state=%0d want 3", aiState);
    end
  endtask

  task automatic test_enable_drop();
    go_track(9'd300, 9'd160);
    clk(1);
    enable = 1'b0;
    clk(1);
    tests++;
    if (aiState !== 2'd0 || button !== 2'b11) begin
      fails++;
      $display("FAIL enable_drop: state=%0d button=%b want 0/11",
               aiState, button);
    end
    enable = 1'b1;
    next_tick();
    tests++;
    if (aiState !== 2'd1 || button !== 2'b11) begin
      fails++;
      $display("FAIL enable_resume: state=%0d button=%b want 1/11",
               aiState, button);
    end
  endtask

  task automatic test_extremes();
    logic [8:0] by [4];
    logic [8:0] py [4];
    logic [1:0] wb [4];
    by = '{9'd0, 9'd511, 9'd0, 9'd0};
    py = '{9'd0, 9'd0, 9'd511, 9'd3};
    wb = '{2'b11, 2'b10, 2'b01, 2'b01};
    go_track(9'd160, 9'd160);
    for (int i = 0; i < 4; i++) begin
      ballY = by[i];
      paddleYValue = py[i];
      next_tick();
      tests++;
      if (button !== wb[i]) begin
        fails++;
        $display("FAIL extreme_%0d_%0d: button=%b want %b",
                 by[i], py[i], button, wb[i]);
      end
    end
  endtask

  task automatic test_random();
    int bad_zero = 0;
    int bad_en = 0;
    logic en_prev;
    do_reset();
    for (int c = 0; c < 10000; c++) begin
      enable = ($urandom_range(0, 15) != 0);
      ballApproach = $urandom_range(0, 1);
      ballY = 9'($urandom_range(0, 511));
      paddleYValue = 9'($urandom_range(0, 511));
      en_prev = enable;
      clk(1);
      if (button === 2'b00) bad_zero++;
      if (!en_prev && (aiState !== 2'd0 || button !== 2'b11)) bad_en++;
    end
    tests++;
    if (bad_zero != 0) begin
      fails++;
      $display("FAIL random_no_00: %0d cycles with 00, want 0", bad_zero);
    end
    tests++;
    if (bad_en != 0) begin
      fails++;
      $display("FAIL random_enable_low: %0d bad cycles, want 0", bad_en);
    end
  endtask

  initial begin
    reset = 1'b1;
    enable = 1'b0;
    ballApproach = 1'b0;
    ballY = '0;
    paddleYValue = '0;
    test_reset();
    test_reaction();
    test_sampling();
    test_deadband();
    test_recenter();
    test_wait_abort();
    test_enable_drop();
    test_extremes();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
